branch_sequencer: RTL
=====================

// Module: branch_sequencer
// PURPOSE
//   Control-unit sequencer that drives the CON flip-flop for conditional branches and consumes its result.
//   Runs the T3..T6 branch steps for one latched instruction word:
//     T3: put Ra on the bus and evaluate CON.
//     T4/T5: compute PC+C.
//     T6: load PC only when CON is true.
//   Sits between the instruction register and datapath strobes; the start/done handshake goes to the main control FSM.
// PARAMETERS
//   OPC_BR  5'b10010  opcode value (IR[31:27]) identifying a branch instruction
//   CNT_W   16        width of the saturating taken-branch counter
// PORTS
//   Clock        in   1      rising-edge clock
//   Clear_n      in   1      asynchronous active-low reset
//   start        in   1      1-cycle request; IR sampled same edge
//   IR           in   32     instruction word
//   hold         in   1      freeze sequence (stall/single-step)
//   CON_Out      in   1      CON flip-flop result
//   cond_bits    out  2      = ir_q[20:19], to CON flip-flop condition_bits
//   Gra          out  1      select Ra field onto register-file read
//   BAout        out  1      register/BA to bus
//   CONin        out  1      CON flip-flop evaluate strobe
//   PCout        out  1      PC to bus
//   Yin          out  1      load Y
//   Cout         out  1      sign-extended C (ir_q[18:0]) to bus
//   ADD          out  1      ALU add select
//   Zin          out  1      load Z
//   Zlowout      out  1      Zlow to bus
//   PCin         out  1      load PC
//   busy         out  1      sequence in progress (state != IDLE)
//   done         out  1      1-cycle completion pulse
//   illegal      out  1      1-cycle pulse: start with non-branch opcode
//   taken        out  1      registered branch decision of last branch
//   taken_count  out  CNT_W  saturating count of taken branches
// BEHAVIOUR
//   Reset (Clear_n=0, async):
//     - state=IDLE; ir_q=0; taken=0; taken_count=0.
//     - Every strobe, done, illegal and busy = 0.
//   States: IDLE, T3, T4, T5, T6, DONE. Binary-encoded state register; strobes are a Moore decode of the state.
//   IDLE:
//     - start=1 with IR[31:27]==OPC_BR: ir_q<=IR, next state T3.
//     - start=1 with any other opcode: ir_q unchanged, next state DONE, illegal=1 during that DONE cycle.
//     - start=0: remain in IDLE.
//   T3: Gra, BAout, CONin=1. At the T3->T4 edge: taken<=CON_Out.
//   T4: PCout, Yin=1.
//   T5: Cout, ADD, Zin=1.
//   T6:
//     - Zlowout=1.
//     - PCin=taken, so a not-taken branch leaves PC untouched.
//     - If taken: taken_count<=taken_count+1, saturating at all-ones (no wrap).
//   DONE: done=1 for exactly one cycle, then IDLE.
//   Latency: start at edge k -> T3 in cycle k+1 -> done in cycle k+5 with no hold; illegal path gives done in cycle k+1.
//   start while busy=1 is ignored; no queueing, ir_q not overwritten.
//   hold=1:
//     - State, ir_q and taken are frozen; all strobes, done and illegal are forced to 0.
//     - On hold release the state resumes, re-asserting its strobes.
//   hold=1 in IDLE blocks start (the request is dropped).
//   taken is not sampled while hold=1 in T3.
//   cond_bits is always driven from ir_q, valid from T3 onward.
//   Reset asserted mid-sequence: immediate return to IDLE, strobes low the same instant; PCin is never issued for an aborted branch.
// TESTING
//   1. Clear_n low mid-T5 -> all outputs 0 asynchronously, busy=0; after release start works normally.
//   2. Taken branch: IR=OPC_BR, cond 00, CON_Out=1 in T3
//      -> CONin in cycle 1, PCin=1 in cycle 4, done in cycle 5, taken=1, taken_count 0->1.
//   3. Not-taken branch: IR=OPC_BR, cond 01, CON_Out=0 in T3
//      -> Zlowout=1, PCin=0 in T6, taken=0, taken_count unchanged.
//   4. Illegal: start with IR[31:27]=5'b00011
//      -> next cycle done=1, illegal=1, no strobes ever asserted, busy low afterwards.
//   5. Hold: assert hold for 3 cycles while in T4
//      -> PCout/Yin low during the hold, state stays T4; done arrives 3 cycles late.
//   6. Back-to-back/saturation: CNT_W=2, four taken branches with start re-pulsed during busy
//      -> extra starts ignored, taken_count ends at 2'b11 (no wrap).

Source files
------------

// File: rtl/branch_sequencer.sv
// Conditional-branch step sequencer (T3..T6) driving the CON flip-flop
// and PC-update strobes for one latched instruction word.
module branch_sequencer #(
  parameter logic [4:0] OPC_BR = 5'b10010,
  parameter int         CNT_W  = 16
) (
  input  logic             Clock,
  input  logic             Clear_n,
  input  logic             start,
  input  logic [31:0]      IR,
  input  logic             hold,
  input  logic             CON_Out,
  output logic [1:0]       cond_bits,
  output logic             Gra,
  output logic             BAout,
  output logic             CONin,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             taken,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T3   = 3'd1;
  localparam logic [2:0] S_T4   = 3'd2;
  localparam logic [2:0] S_T5   = 3'd3;
  localparam logic [2:0] S_T6   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state;
  logic [31:0] ir_q;
  logic        ill_q;
  logic        unused_ir;

  // Only the condition field leaves this block; the rest of ir_q
  // is kept as the latched instruction word.
  assign unused_ir = ^{ir_q[31:21], ir_q[18:0]};
  assign cond_bits = ir_q[20:19];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state       <= S_IDLE;
      ir_q        <= '0;
      ill_q       <= 1'b0;
      taken       <= 1'b0;
      taken_count <= '0;
    end else if (!hold) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (IR[31:27] == OPC_BR) begin
              ir_q  <= IR;
              state <= S_T3;
            end else begin
              ill_q <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_T3: begin
          taken <= CON_Out;
          state <= S_T4;
        end
        S_T4: state <= S_T5;
        S_T5: state <= S_T6;
        S_T6: begin
          if (taken && !(&taken_count))
            taken_count <= taken_count + 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          ill_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; hold blanks every strobe without disturbing state.
  always_comb begin
    Gra     = 1'b0;
    BAout   = 1'b0;
    CONin   = 1'b0;
    PCout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ADD     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    if (!hold) begin
      unique case (1'b1)
        (state == S_T3): begin
          Gra   = 1'b1;
          BAout = 1'b1;
          CONin = 1'b1;
        end
        (state == S_T4): begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
        (state == S_T5): begin
          Cout = 1'b1;
          ADD  = 1'b1;
          Zin  = 1'b1;
        end
        (state == S_T6): begin
          Zlowout = 1'b1;
          PCin    = taken;
        end
        (state == S_DONE): begin
          done    = 1'b1;
          illegal = ill_q;
        end
        default: ;
      endcase
    end
  end

endmodule
